// File: rtl/relprime_job_sequencer_if.sv
// Host/core-facing bus of the relprime job sequencer.
// slave: the sequencer's view. master: the host/core-model view.
interface relprime_job_sequencer_if #(
    parameter int DATA_W = 16
);
    // operand stream in
    logic [DATA_W-1:0] in_value;
    logic              in_valid;
    logic              in_ready;
    // relprime core side
    logic [DATA_W-1:0] proc_value;
    logic [DATA_W-1:0] proc_two;
    logic [DATA_W-1:0] proc_one;
    logic              proc_start;
    logic [DATA_W-1:0] proc_out;
    logic              proc_done;
    // result stream out
    logic [DATA_W-1:0] res_operand;
    logic [DATA_W-1:0] res_value;
    logic              res_valid;
    logic              res_ready;
    // status
    logic              busy;
    logic              err;

    modport slave (
        input  in_value, in_valid, proc_out, proc_done, res_ready,
        output in_ready, proc_value, proc_two, proc_one, proc_start,
               res_operand, res_value, res_valid, busy, err
    );

    modport master (
        output in_value, in_valid, proc_out, proc_done, res_ready,
        input  in_ready, proc_value, proc_two, proc_one, proc_start,
               res_operand, res_value, res_valid, busy, err
    );
endinterface

// File: rtl/relprime_job_sequencer.sv
// relprime_job_sequencer: queues operands, launches one relprime core job
// at a time, and returns {operand, result} pairs on a valid/ready port.
// Optional job watchdog enabled by defining RELPRIME_TIMEOUT_EN.
module relprime_job_sequencer #(
    parameter int DATA_W         = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic                     CLK,
    input logic                     reset,
    relprime_job_sequencer_if.slave bus
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        START_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("relprime_job_sequencer: invalid parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

    state_t                           state_q, state_d;
    logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [PW-1:0]                    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                    rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]                operand_q, operand_d;
    logic [DATA_W-1:0]                res_value_q, res_value_d;
    logic [SCW-1:0]                   start_cnt_q, start_cnt_d;
`ifdef RELPRIME_TIMEOUT_EN
    logic [31:0]                      wd_q, wd_d;
    logic                             err_q, err_d;
`endif

    logic empty, full, in_ready, push;

    // Pointer MSB distinguishes full from empty when the low bits match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready = !full && !reset;
    assign push     = bus.in_valid && in_ready;

    // Next-state, FIFO bookkeeping and job capture.
    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        operand_d   = operand_q;
        res_value_d = res_value_q;
        start_cnt_d = start_cnt_q;
`ifdef RELPRIME_TIMEOUT_EN
        err_d       = err_q;
        // Zero outside WAIT, so it is already clear on WAIT entry.
        wd_d        = (state_q == S_WAIT) ? wd_q + 32'd1 : 32'd0;
`endif
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = bus.in_value;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    operand_d   = mem_q[rd_ptr_q[AW-1:0]];
                    rd_ptr_d    = rd_ptr_q + PW'(1);
                    start_cnt_d = '0;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // Any early proc_done is ignored here by construction.
                if (start_cnt_q == SCW'(START_CYCLES - 1)) state_d = S_WAIT;
                else start_cnt_d = start_cnt_q + SCW'(1);
            end
            S_WAIT: begin
                if (bus.proc_done) begin
                    res_value_d = bus.proc_out;
`ifdef RELPRIME_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    state_d     = S_HOLD;
                end
`ifdef RELPRIME_TIMEOUT_EN
                else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    res_value_d = '0;
                    err_d       = 1'b1;
                    state_d     = S_HOLD;
                end
`endif
            end
            S_HOLD: begin
                if (bus.res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers; reset abandons any job in flight.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            operand_q   <= '0;
            res_value_q <= '0;
            start_cnt_q <= '0;
`ifdef RELPRIME_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            operand_q   <= operand_d;
            res_value_q <= res_value_d;
            start_cnt_q <= start_cnt_d;
`ifdef RELPRIME_TIMEOUT_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    // Queue storage; contents are don't-care once the pointers are flushed.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    // Outputs are forced to 0 while reset is asserted.
    assign bus.in_ready    = in_ready;
    assign bus.proc_value  = reset ? '0 : operand_q;
    assign bus.proc_two    = DATA_W'(2);
    assign bus.proc_one    = DATA_W'(1);
    assign bus.proc_start  = !reset && (state_q == S_LAUNCH);
    assign bus.res_operand = reset ? '0 : operand_q;
    assign bus.res_value   = reset ? '0 : res_value_q;
    assign bus.res_valid   = !reset && (state_q == S_HOLD);
    assign bus.busy        = !reset && ((state_q != S_IDLE) || !empty);
`ifdef RELPRIME_TIMEOUT_EN
    assign bus.err         = !reset && err_q;
`else
    assign bus.err         = 1'b0;
`endif
endmodule

// File: tb/tb_relprime_job_sequencer.sv
// Bench for relprime_job_sequencer: behavioural relprime core model,
// scoreboard of expected result pairs, table-driven queue fill.
module tb_relprime_job_sequencer;
    localparam int DW = 16;

    logic CLK;
    logic reset;
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    relprime_job_sequencer_if #(.DATA_W(DW)) bus_if ();

    relprime_job_sequencer #(
        .DATA_W(DW), .FIFO_DEPTH(4), .START_CYCLES(2), .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK(CLK), .reset(reset), .bus(bus_if)
    );

    typedef struct { logic [15:0] op; logic [15:0] val; logic err; } res_t;
    typedef struct { logic [15:0] op; logic rdy; logic [15:0] res; } vec_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   core_delay;
    bit   core_auto;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    // Smallest m >= 2 coprime with n (what the real core computes).
    function automatic logic [15:0] relprime(input logic [15:0] n);
        logic [15:0] a, b, t;
        for (int m = 2; m < 200; m++) begin
            a = n;
            b = 16'(m);
            while (b != 0) begin
                t = a % b;
                a = b;
                b = t;
            end
            if (a == 16'd1) return 16'(m);
        end
        return 16'd0;
    endfunction

    // Core model: pulses done core_delay cycles after start falls.
    initial begin
        int cnt;
        bit prev;
        logic [15:0] op;
        cnt = 0; prev = 0; op = '0;
        forever begin
            tick();
            if (reset) begin
                cnt  = 0;
                prev = 0;
                if (core_auto) bus_if.proc_done = 1'b0;
            end else if (core_auto) begin
                bus_if.proc_done = 1'b0;
                if (bus_if.proc_start) op = bus_if.proc_value;
                if (prev && !bus_if.proc_start) cnt = core_delay;
                else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus_if.proc_done = 1'b1;
                        bus_if.proc_out  = relprime(op);
                    end
                end
                prev = bus_if.proc_start;
            end else begin
                cnt  = 0;
                prev = bus_if.proc_start;
            end
        end
    end

    // Result monitor: every accepted pair must match the scoreboard head.
    initial begin
        res_t e;
        forever begin
            smp();
            if (!reset && bus_if.res_valid && bus_if.res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got op %0d val %0d, none expected",
                             bus_if.res_operand, bus_if.res_value);
                end else begin
                    e = sb.pop_front();
                    chk("res_operand", bus_if.res_operand, e.op);
                    chk("res_value", bus_if.res_value, e.val);
                    chk("res_err", bus_if.err, e.err);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_op(input logic [15:0] v);
        tick();
        bus_if.in_value = v;
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
    endtask

    // Waits through a LAUNCH; returns at the first WAIT-cycle sample.
    task automatic wait_launch(input string name, output int starts, output logic [15:0] val);
        bit seen;
        int n;
        seen = 0; n = 0; starts = 0; val = '0;
        while (n < 60) begin
            smp();
            n++;
            if (bus_if.proc_start) begin
                starts++;
                val  = bus_if.proc_value;
                seen = 1;
            end else if (seen) break;
        end
        chk(name, {31'd0, seen && !bus_if.proc_start}, 32'd1);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            smp();
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    initial begin
        vec_t tbl[5];
        int starts, bad, n;
        bit got;
        logic [15:0] v;

        tbl[0] = '{16'd6,     1'b1, 16'd5};
        tbl[1] = '{16'd10,    1'b1, 16'd3};
        tbl[2] = '{16'd30,    1'b1, 16'd7};
        tbl[3] = '{16'd210,   1'b1, 16'd11};
        tbl[4] = '{16'd34596, 1'b1, 16'd5};

        reset = 1'b1;
        bus_if.in_value = '0; bus_if.in_valid = 1'b0; bus_if.res_ready = 1'b0;
        bus_if.proc_done = 1'b0; bus_if.proc_out = '0;
        core_auto = 1; core_delay = 40;

        // ---- reset state ----
        tick();
        smp();
        chk("rst_in_ready", bus_if.in_ready, 0);
        chk("rst_proc_start", bus_if.proc_start, 0);
        chk("rst_res_valid", bus_if.res_valid, 0);
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_err", bus_if.err, 0);
        chk("rst_proc_two", bus_if.proc_two, 2);
        chk("rst_proc_one", bus_if.proc_one, 1);
        chk("rst_proc_value", bus_if.proc_value, 0);
        chk("rst_res_value", bus_if.res_value, 0);
        tick();
        reset = 1'b0;
        smp();
        chk("post_rst_in_ready", bus_if.in_ready, 1);
        chk("post_rst_busy", bus_if.busy, 0);

        // ---- single job ----
        bus_if.res_ready = 1'b1;
        sb.push_back('{16'd34596, 16'd5, 1'b0});
        push_op(16'd34596);
        wait_launch("single_launch", starts, v);
        chk("single_start_cycles", starts, 2);
        chk("single_start_value", v, 34596);
        chk("single_proc_two", bus_if.proc_two, 2);
        chk("single_proc_one", bus_if.proc_one, 1);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            smp();
            if (bus_if.proc_done) got = 1;
        end
        chk("single_done_seen", got, 1);
        chk("single_valid_at_done", bus_if.res_valid, 0);
        smp();
        chk("single_valid_after_done", bus_if.res_valid, 1);
        drain("single_drain", 10);
        tick();
        tick();
        smp();
        chk("single_idle", bus_if.busy, 0);

        // ---- queue fill to full, table-driven ----
        core_delay = 5;
        bus_if.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus_if.in_value = tbl[i].op;
            bus_if.in_valid = 1'b1;
            smp();
            chk($sformatf("fill_in_ready_%0d", i), bus_if.in_ready, tbl[i].rdy);
            sb.push_back('{tbl[i].op, tbl[i].res, 1'b0});
        end
        tick();
        bus_if.in_value = 16'd999;
        smp();
        chk("fill_full", bus_if.in_ready, 0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            smp();
            if (bus_if.in_ready !== 1'b0) bad++;
        end
        chk("fill_full_held", bad, 0);
        tick();
        bus_if.in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            tick();
            bus_if.res_ready = (n % 3 != 0);
            n++;
        end
        chk("fill_drain", sb.size(), 0);
        tick();
        bus_if.res_ready = 1'b0;
        tick();
        smp();
        chk("fill_in_ready_after", bus_if.in_ready, 1);

        // ---- backpressure ----
        sb.push_back('{16'd10, 16'd3, 1'b0});
        sb.push_back('{16'd30, 16'd7, 1'b0});
        push_op(16'd10);
        push_op(16'd30);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            smp();
            if (bus_if.res_valid) got = 1;
        end
        chk("bp_valid_seen", got, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (bus_if.res_valid !== 1'b1 || bus_if.res_operand !== 16'd10 ||
                bus_if.res_value !== 16'd3 || bus_if.err !== 1'b0 ||
                bus_if.proc_start !== 1'b0) bad++;
        end
        chk("bp_stable", bad, 0);
        tick();
        bus_if.res_ready = 1'b1;
        tick();
        bus_if.res_ready = 1'b0;
        smp();
        chk("bp_accept_start0", bus_if.proc_start, 0);
        chk("bp_accept_valid0", bus_if.res_valid, 0);
        tick();
        smp();
        chk("bp_next_start", bus_if.proc_start, 1);
        chk("bp_next_value", bus_if.proc_value, 30);
        bus_if.res_ready = 1'b1;
        drain("bp_drain", 100);
        tick();
        tick();

        // ---- reset mid-job ----
        core_delay = 40;
        push_op(16'd30);
        wait_launch("rst_job_launch", starts, v);
        push_op(16'd6);
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        smp();
        chk("midrst_proc_start", bus_if.proc_start, 0);
        chk("midrst_res_valid", bus_if.res_valid, 0);
        chk("midrst_in_ready", bus_if.in_ready, 1);
        chk("midrst_fifo_empty", bus_if.busy, 0);
        core_auto = 0;
        tick();
        tick();
        bus_if.proc_out  = 16'd77;
        bus_if.proc_done = 1'b1;
        tick();
        bus_if.proc_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            smp();
            if (bus_if.res_valid !== 1'b0 || bus_if.busy !== 1'b0) bad++;
        end
        chk("midrst_stale_done", bad, 0);

`ifdef RELPRIME_TIMEOUT_EN
        // ---- watchdog expiry ----
        bus_if.res_ready = 1'b0;
        push_op(16'd30);
        wait_launch("to_launch", starts, v);
        n = 1;
        while (n < 300) begin
            smp();
            if (bus_if.res_valid) break;
            n++;
        end
        chk("to_wait_cycles", n, 100);
        chk("to_err", bus_if.err, 1);
        chk("to_value", bus_if.res_value, 0);
        sb.push_back('{16'd30, 16'd0, 1'b1});
        tick();
        bus_if.res_ready = 1'b1;
        drain("to_drain", 10);
        tick();
        bus_if.res_ready = 1'b0;
        tick();

        // ---- done on the timeout cycle wins ----
        push_op(16'd10);
        wait_launch("to2_launch", starts, v);
        for (int t = 1; t <= 99; t++) tick();
        bus_if.proc_out  = 16'd1234;
        bus_if.proc_done = 1'b1;
        tick();
        bus_if.proc_done = 1'b0;
        smp();
        chk("to2_valid", bus_if.res_valid, 1);
        chk("to2_err", bus_if.err, 0);
        chk("to2_value", bus_if.res_value, 1234);
        sb.push_back('{16'd10, 16'd1234, 1'b0});
        tick();
        bus_if.res_ready = 1'b1;
        drain("to2_drain", 10);
`else
        // ---- no watchdog: WAIT holds until done arrives ----
        bus_if.res_ready = 1'b0;
        push_op(16'd30);
        wait_launch("nto_launch", starts, v);
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            smp();
            if (bus_if.res_valid !== 1'b0) bad++;
        end
        chk("nto_no_result", bad, 0);
        tick();
        bus_if.proc_out  = 16'd7;
        bus_if.proc_done = 1'b1;
        tick();
        bus_if.proc_done = 1'b0;
        smp();
        chk("nto_valid", bus_if.res_valid, 1);
        chk("nto_err", bus_if.err, 0);
        sb.push_back('{16'd30, 16'd7, 1'b0});
        tick();
        bus_if.res_ready = 1'b1;
        drain("nto_drain", 10);
`endif
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/relprime_job_sequencer.md
Name: relprime_job_sequencer

Overview:
- Sits directly upstream and downstream of the relprime processor core (`top_level`). It buffers incoming operands and launches one relprime job at a time.
- It drives the core's operand and constant ports and start strobe, then captures the core's result when the core signals done.
- It presents {operand, result} pairs on a valid/ready output port, so host logic can stream many values through the multi-cycle core without hand-sequencing `start`.

Parameters:
- DATA_W, 16, operand/result width; matches the core's 16-bit datapath.
- FIFO_DEPTH, 4, operand queue entries; power of two, ≥2.
- START_CYCLES, 2, number of cycles `proc_start` is held high per job.
- TIMEOUT_CYCLES, 65535, watchdog limit on job duration; used only with the optional feature.

Ports:
- CLK  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_value  in  DATA_W  operand to compute relprime of.
- in_valid  in  1  operand present.
- in_ready  out  1  queue can accept; equals !full.
- proc_value  out  DATA_W  drives the core's `register_value`.
- proc_two  out  DATA_W  constant 2 to the core's `decimal_two`.
- proc_one  out  DATA_W  constant 1 to the core's `decimal_one`.
- proc_start  out  1  core start strobe.
- proc_out  in  DATA_W  core result.
- proc_done  in  1  one-cycle pulse from the core when `proc_out` is final.
- res_operand  out  DATA_W  operand of the completed job.
- res_value  out  DATA_W  relprime result; 0 on timeout.
- res_valid  out  1  result pair valid.
- res_ready  in  1  consumer accepts result.
- busy  out  1  high in any state except IDLE, or while the FIFO is non-empty.
- err  out  1  result is a timeout error; valid with `res_valid`.

Behaviour:
- Reset (synchronous, wins over everything):
  - Flushes the FIFO and sets state=IDLE.
  - All outputs are 0, except `proc_two`=2 and `proc_one`=1, which are constant.
  - `in_ready` is 1 the cycle after reset deasserts.
  - A job in flight is abandoned. `proc_start` is low from the reset cycle onward; the core is expected to idle.
- FIFO:
  - Push when `in_valid && in_ready`; pop in IDLE when non-empty.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap.
  - Full: `in_ready`=0 and the push is ignored.
  - Push and pop on the same cycle when full: pop frees the slot but `in_ready` is still 0 that cycle, so there is no push.
  - Push and pop on the same cycle when empty: not possible, since pop needs non-empty registered state.
- IDLE:
  - If FIFO non-empty, latch the head into an operand register (drives `proc_value` and `res_operand`), pop, and go to LAUNCH.
- LAUNCH:
  - `proc_start`=1 for exactly START_CYCLES cycles, counted from the LAUNCH entry, then go to WAIT.
  - `proc_value` is stable from LAUNCH entry until the next IDLE.
- WAIT:
  - `proc_start`=0.
  - On `proc_done`, capture `proc_out` into `res_value`, set `err`=0, go to HOLD.
  - A `proc_done` seen during LAUNCH is ignored; the core cannot finish before start drops.
- HOLD:
  - `res_valid`=1. `res_operand`, `res_value` and `err` are stable until `res_valid && res_ready`.
  - On accept, go to IDLE; `res_valid` drops the next cycle.
- Latency:
  - Head of non-empty FIFO to `proc_start` rise: 1 cycle.
  - `proc_done` to `res_valid`: 1 cycle.
  - Back-to-back jobs: IDLE costs 1 cycle between an accept and the next LAUNCH.
- Backpressure: while HOLD is stalled, the FIFO keeps accepting until full. No second job launches.
- Width: no arithmetic on operands. Operand 0 or 1 is passed to the core unchanged; the result is whatever the core returns.

Optional Feature:
- Macro: RELPRIME_TIMEOUT_EN.
- With the macro defined:
  - A 32-bit cycle counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without `proc_done`, go to HOLD with `res_value`=0 and `err`=1.
  - A `proc_done` on the same cycle as the timeout wins: normal result, `err`=0.
- Without the macro: no counter, WAIT waits indefinitely, and `err` is tied to 0.

Test Plan:
- Single job: reset 2 cycles; push 34596; the core model returns 5 after 40 cycles.
  - Required: `proc_start` high 2 cycles with `proc_value`=34596, `proc_two`=2, `proc_one`=1.
  - Required: `res_valid` 1 cycle after `proc_done`, with `res_operand`=34596, `res_value`=5, `err`=0.
- Queue/full: push 5 operands (6, 10, 30, 210, 34596) back-to-back with `res_ready`=0.
  - Required: `in_ready` drops after the 4th queued entry (one job in flight plus 4 queued).
  - Required: results appear in order 5, 3, 7, 11, 5 as `res_ready` is toggled.
- Backpressure: hold `res_ready`=0 for 20 cycles after `res_valid`.
  - Required: outputs stable and no second `proc_start` until accept.
  - Required: next `proc_start` exactly 2 cycles after the accept edge.
- Reset mid-job: assert reset during WAIT of job 30.
  - Required: next cycle `proc_start`=0, `res_valid`=0, `in_ready`=1, FIFO empty.
  - Required: a stale `proc_done` afterwards is ignored.
- Timeout (RELPRIME_TIMEOUT_EN, TIMEOUT_CYCLES=100): the core never pulses done.
  - Required: `res_valid` with `err`=1 and `res_value`=0 after 100 WAIT cycles.
  - Repeat with `proc_done` on cycle 100: `err`=0 and the real result is captured.
